// File: rtl/btn_pkg.sv
// Shared defaults and sizing helper for the push-button bank.
package btn_pkg;

  localparam int unsigned N_BTN_DEF           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned LONG_CYCLES_DEF     = 100_000_000;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debouncer, hold counter and toggle.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int unsigned LONG_CLEARS     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pressed,
  output logic released,
  output logic long_press,
  output logic toggle
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic              pressed_q, pressed_d;
  logic              released_q, released_d;
  logic              long_q, long_d;
  logic              toggle_q, toggle_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Next-state: sync chain, debounce acceptance, hold tracking and toggle.
  always_comb begin
    sync1_d    = btn;
    sync2_d    = sync1_q;
    level_d    = level_q;
    db_cnt_d   = db_cnt_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    long_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;
    toggle_d   = toggle_q;

    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d    = sync2_q;
      db_cnt_d   = '0;
      pressed_d  = sync2_q;
      released_d = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      long_d     = (hold_cnt_q == HOLD_PRE);
    end

    if (pressed_d) begin
      toggle_d = ~toggle_q;
    end
    if (long_d && (LONG_CLEARS != 0)) begin
      toggle_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
      toggle_q   <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      long_q     <= long_d;
      toggle_q   <= toggle_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign level      = level_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign long_press = long_q;
  assign toggle     = toggle_q;

endmodule

// File: rtl/button_bank.sv
// Bank of independent debounced button channels.
module button_bank
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int unsigned LONG_CLEARS     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] released,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] toggle
);

  // One identical channel per button pin.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .LONG_CLEARS     (LONG_CLEARS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn[i]),
      .level      (level[i]),
      .pressed    (pressed[i]),
      .released   (released[i]),
      .long_press (long_press[i]),
      .toggle     (toggle[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: expected pulses are queued with the edge
// they must appear on; a negedge monitor pops and compares them every cycle.
module tb_button_bank;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;
  localparam int unsigned L = 16;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_e;
  typedef struct {
    int unsigned edge_no;
    int          ch;
    ev_kind_e    kind;
  } ev_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] level, pressed, released, long_press, toggle;
  logic [N-1:0] nc_level, nc_pressed, nc_released, nc_long, nc_toggle;

  button_bank #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .LONG_CLEARS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .level(level), .pressed(pressed),
    .released(released), .long_press(long_press), .toggle(toggle)
  );

  button_bank #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .LONG_CLEARS(0)
  ) u_dut_nc (
    .clk(clk), .rst(rst), .btn(btn), .level(nc_level), .pressed(nc_pressed),
    .released(nc_released), .long_press(nc_long), .toggle(nc_toggle)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int unsigned edge_n  = 0;
  logic        rst_s   = 1'b0;
  ev_t         sb_q[$];

  logic [N-1:0] exp_level  = '0;
  logic [N-1:0] exp_tog    = '0;
  logic [N-1:0] exp_tog_nc = '0;
  logic [N-1:0] ep, er, el;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  // Edge counter and the reset value seen by the DUT at that edge.
  always @(posedge clk) begin
    edge_n++;
    rst_s = rst;
  end

  // Monitor: retire events due at this edge and compare all outputs.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      ep = '0; er = '0; el = '0;
      if (rst_s) begin
        exp_level  = '0;
        exp_tog    = '0;
        exp_tog_nc = '0;
      end else begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
          if (sb_q[i].edge_no < edge_n) begin
            chk("missed_event", 32'(sb_q[i].edge_no), 32'(edge_n));
            sb_q.delete(i);
          end else if (sb_q[i].edge_no == edge_n) begin
            case (sb_q[i].kind)
              EV_PRESS: begin
                ep[sb_q[i].ch]         = 1'b1;
                exp_level[sb_q[i].ch]  = 1'b1;
                exp_tog[sb_q[i].ch]    = ~exp_tog[sb_q[i].ch];
                exp_tog_nc[sb_q[i].ch] = ~exp_tog_nc[sb_q[i].ch];
              end
              EV_RELEASE: begin
                er[sb_q[i].ch]        = 1'b1;
                exp_level[sb_q[i].ch] = 1'b0;
              end
              default: begin
                el[sb_q[i].ch]      = 1'b1;
                exp_tog[sb_q[i].ch] = 1'b0;
              end
            endcase
            sb_q.delete(i);
          end
        end
      end
      chk("pressed",    32'(pressed),    32'(ep));
      chk("released",   32'(released),   32'(er));
      chk("long_press", 32'(long_press), 32'(el));
      chk("level",      32'(level),      32'(exp_level));
      chk("toggle",     32'(toggle),     32'(exp_tog));
      chk("nc_pulses",  32'({nc_pressed, nc_released, nc_long}), 32'({ep, er, el}));
      chk("nc_level",   32'(nc_level),   32'(exp_level));
      chk("nc_toggle",  32'(nc_toggle),  32'(exp_tog_nc));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue pulses for a level that became high at the next sampling edge.
  task automatic sched_press(input int ch);
    ev_t e;
    e.ch = ch;
    e.kind = EV_PRESS;  e.edge_no = edge_n + 2 + D;     sb_q.push_back(e);
    e.kind = EV_LONG;   e.edge_no = edge_n + 2 + D + L; sb_q.push_back(e);
  endtask

  task automatic press(input int ch);
    btn[ch] = 1'b1;
    sched_press(ch);
  endtask

  // A release cancels the long press if the level falls before it is due.
  task automatic release_btn(input int ch);
    ev_t e;
    int unsigned r;
    btn[ch] = 1'b0;
    r = edge_n + 2 + D;
    for (int i = sb_q.size() - 1; i >= 0; i--)
      if (sb_q[i].ch == ch && sb_q[i].kind == EV_LONG && sb_q[i].edge_no > r)
        sb_q.delete(i);
    e.ch = ch; e.kind = EV_RELEASE; e.edge_no = r;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    sb_q.delete();
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  initial begin
    btn = '0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Clean press and release on channel 0.
    press(0);
    cycles(12);
    release_btn(0);
    cycles(12);

    // Glitch shorter than the debounce window on channel 1.
    btn[1] = 1'b1;
    cycles(3);
    btn[1] = 1'b0;
    cycles(10);

    // Two short presses on channel 2: toggle 0 -> 1 -> 0, no long press.
    press(2);
    cycles(14);
    release_btn(2);
    cycles(12);
    press(2);
    cycles(14);
    release_btn(2);
    cycles(12);

    // Long hold on channel 3: one long pulse, toggle cleared only when enabled.
    press(3);
    cycles(36);
    release_btn(3);
    cycles(12);

    // All channels rise on the same edge.
    for (int c = 0; c < int'(N); c++) press(c);
    cycles(10);
    for (int c = 0; c < int'(N); c++) release_btn(c);
    cycles(12);

    // Reset during debounce, button still held afterwards.
    press(0);
    cycles(3);
    do_reset(1);
    sched_press(0);
    cycles(10);
    release_btn(0);
    cycles(12);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
